// File: rtl/psum_drain.sv
// rtl/psum_drain.sv - drains a contiguous run of psum BRAM entries onto an AXI4-Stream master
//
// Ports:
//   clk, rst_n                  rising-edge clock, synchronous active-low reset
//   start, start_addr,          one-cycle request (IDLE only), first address,
//   num_words, relu_en          entry count (clamped to DEPTH), per-lane ReLU enable
//   busy, done                  transfer in progress / one-cycle completion pulse
//   bram_en, bram_addr,         BRAM read port; bram_dout is valid the cycle
//   bram_dout                   after bram_en
//   m_axis_tdata/tvalid/        stream master toward the output DMA,
//   tready/tlast                tlast on the final entry
module psum_drain #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 324,
  parameter int LANE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  relu_en,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_N   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   reads_left;
  logic                  relu_q;
  logic                  rd_pending;
  logic                  rd_pending_last;

  // Two-slot shift FIFO: slot0 is always the head, so the stream outputs
  // come straight from registers.
  logic [DATA_WIDTH-1:0] slot0_data, slot1_data;
  logic                  slot0_last, slot1_last;
  logic [1:0]            fifo_cnt;

  logic                  pop;
  logic                  issue;
  logic                  issue_last;
  logic [2:0]            occ;
  logic [ADDR_WIDTH:0]   words_clamped;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] addr_next;

  assign words_clamped = (num_words > DEPTH_N) ? DEPTH_N : num_words;

  assign m_axis_tvalid = (fifo_cnt != 2'd0);
  assign m_axis_tdata  = slot0_data;
  // slot0_last can be stale once the FIFO empties, so gate it with valid.
  assign m_axis_tlast  = m_axis_tvalid & slot0_last;
  assign pop           = m_axis_tvalid & m_axis_tready;

  // Occupancy counts the read in flight and credits this cycle's pop, so
  // the FIFO can never be asked to hold a third entry.
  assign occ        = 3'(fifo_cnt) + 3'(rd_pending) - 3'(pop);
  assign issue      = (state == S_RUN) && (reads_left != '0) && (occ < 3'd2);
  assign issue_last = issue && (reads_left == (ADDR_WIDTH+1)'(1));

  assign bram_en   = issue;
  assign addr_next = (bram_addr == LAST_ADDR) ? '0 : bram_addr + ADDR_WIDTH'(1);

  assign busy = (state == S_RUN) || (state == S_FLUSH);
  assign done = (state == S_DONE);

  always_comb begin
    wr_data = bram_dout;
    if (relu_q) begin
      for (int l = 0; l < LANES; l++) begin
        if (bram_dout[l*LANE_WIDTH + LANE_WIDTH - 1]) begin
          wr_data[l*LANE_WIDTH +: LANE_WIDTH] = '0;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (words_clamped == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue_last) begin
          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (pop && slot0_last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      bram_addr       <= '0;
      reads_left      <= '0;
      relu_q          <= 1'b0;
      rd_pending      <= 1'b0;
      rd_pending_last <= 1'b0;
      slot0_data      <= '0;
      slot1_data      <= '0;
      slot0_last      <= 1'b0;
      slot1_last      <= 1'b0;
      fifo_cnt        <= 2'd0;
    end else begin
      state           <= state_nxt;
      rd_pending      <= issue;
      rd_pending_last <= issue_last;

      if ((state == S_IDLE) && start) begin
        bram_addr  <= start_addr;
        reads_left <= words_clamped;
        relu_q     <= relu_en;
      end else if (issue) begin
        bram_addr  <= addr_next;
        reads_left <= reads_left - (ADDR_WIDTH+1)'(1);
      end

      case ({rd_pending, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) begin
            slot0_data <= wr_data;
            slot0_last <= rd_pending_last;
          end else begin
            slot1_data <= wr_data;
            slot1_last <= rd_pending_last;
          end
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          slot0_data <= slot1_data;
          slot0_last <= slot1_last;
          fifo_cnt   <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            slot0_data <= wr_data;
            slot0_last <= rd_pending_last;
          end else begin
            slot0_data <= slot1_data;
            slot0_last <= slot1_last;
            slot1_data <= wr_data;
            slot1_last <= rd_pending_last;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// tb/tb_psum_drain.sv - self-checking bench for psum_drain
module tb_psum_drain;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [8:0]   start_addr;
  logic [9:0]   num_words;
  logic         relu_en;
  logic         busy;
  logic         done;
  logic         bram_en;
  logic [8:0]   bram_addr;
  logic [127:0] bram_dout;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;

  int checks   = 0;
  int failures = 0;
  int hs_total = 0;

  logic [127:0] mem [0:323];
  logic [8:0]   rd_addrs [$];

  localparam logic [127:0] RELU_PAT = {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001,
                                       16'h0000, 16'h1234, 16'hF000, 16'h0F00};
  localparam logic [127:0] RELU_EXP = {16'h0000, 16'h7FFF, 16'h0000, 16'h0001,
                                       16'h0000, 16'h1234, 16'h0000, 16'h0F00};

  typedef struct {
    logic [8:0]   saddr;
    logic [9:0]   nwords;
    logic         relu;
    int           mode;      // 0: ready high, 1: 1,0,0,1,0,1 pattern, 2: random
    logic         poke;      // pulse start mid-transfer
    int           exp_beats;
    logic         chk_first;
    logic [127:0] exp_first;
  } vec_t;

  vec_t vecs [9];

  psum_drain dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_addr    (start_addr),
    .num_words     (num_words),
    .relu_en       (relu_en),
    .busy          (busy),
    .done          (done),
    .bram_en       (bram_en),
    .bram_addr     (bram_addr),
    .bram_dout     (bram_dout),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_en) begin
      bram_dout <= mem[bram_addr];
      rd_addrs.push_back(bram_addr);
    end
    if (rst_n && m_axis_tvalid && m_axis_tready) hs_total <= hs_total + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_data(input logic [8:0] sa, input int b, input logic relu);
    logic [127:0] d;
    d = mem[(int'(sa) + b) % 324];
    if (relu) begin
      for (int l = 0; l < 8; l++) begin
        if (d[l*16 + 15]) d[l*16 +: 16] = 16'h0000;
      end
    end
    return d;
  endfunction

  function automatic logic ready_for(input int mode, input int c);
    logic [5:0] pat;
    pat = 6'b101001;  // bit c%6: 1,0,0,1,0,1
    case (mode)
      0:       return 1'b1;
      1:       return pat[c % 6];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Returns at the falling edge of the done cycle (or on timeout).
  task automatic run_vec(input int vi, input vec_t v);
    int beats = 0, issued = 0, popped = 0, done_cnt = 0;
    int first_valid = -1, first_hs = -1, last_hs = -1, done_cyc = -1;
    int bound, bad_addr;
    logic prev_stall = 1'b0;
    logic prev_last = 1'b0;
    logic [127:0] prev_data = '0;
    bound = v.exp_beats * 6 + 30;
    rd_addrs.delete();
    @(negedge clk);
    start = 1'b1; start_addr = v.saddr; num_words = v.nwords; relu_en = v.relu;
    @(posedge clk); #1;
    start = 1'b0; start_addr = 9'd7; num_words = 10'd2; relu_en = ~v.relu;
    for (int c = 0; c < bound; c++) begin
      m_axis_tready = ready_for(v.mode, c);
      if (v.poke && c == 5) begin
        start = 1'b1; start_addr = 9'd0; num_words = 10'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (prev_stall) begin
        check($sformatf("v%0d c%0d stall_valid", vi, c), 128'(m_axis_tvalid), 128'(1));
        check($sformatf("v%0d c%0d stall_data", vi, c), m_axis_tdata, prev_data);
        check($sformatf("v%0d c%0d stall_last", vi, c), 128'(m_axis_tlast), 128'(prev_last));
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (m_axis_tvalid && first_valid < 0) first_valid = c;
      if (bram_en) issued++;
      if (m_axis_tvalid && m_axis_tready) begin
        popped++;
        check($sformatf("v%0d beat%0d data", vi, beats), m_axis_tdata,
              exp_data(v.saddr, beats, v.relu));
        check($sformatf("v%0d beat%0d last", vi, beats), 128'(m_axis_tlast),
              128'(beats == v.exp_beats - 1));
        if (beats == 0 && v.chk_first)
          check($sformatf("v%0d first_beat", vi), m_axis_tdata, v.exp_first);
        if (first_hs < 0) first_hs = c;
        last_hs = c;
        beats++;
      end
      if (bram_en)
        check($sformatf("v%0d c%0d occupancy_le2", vi, c), 128'(issued - popped <= 2), 128'(1));
      if (done) begin
        done_cnt++;
        done_cyc = c;
        check($sformatf("v%0d busy_at_done", vi), 128'(busy), 128'(0));
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check($sformatf("v%0d beat_count", vi), 128'(beats), 128'(v.exp_beats));
    check($sformatf("v%0d done_count", vi), 128'(done_cnt), 128'(1));
    check($sformatf("v%0d read_count", vi), 128'(rd_addrs.size()), 128'(v.exp_beats));
    bad_addr = 0;
    foreach (rd_addrs[j]) if (int'(rd_addrs[j]) != (int'(v.saddr) + j) % 324) bad_addr++;
    check($sformatf("v%0d read_addr_errors", vi), 128'(bad_addr), 128'(0));
    if (v.exp_beats > 0) begin
      check($sformatf("v%0d first_valid_cycle", vi), 128'(first_valid), 128'(2));
      check($sformatf("v%0d done_after_last", vi), 128'(done_cyc), 128'(last_hs + 1));
      if (v.mode == 0)
        check($sformatf("v%0d no_bubble_span", vi), 128'(last_hs - first_hs), 128'(v.exp_beats - 1));
    end else begin
      check($sformatf("v%0d zero_done_cycle", vi), 128'(done_cyc), 128'(0));
    end
  endtask

  initial begin
    int done_seen;
    for (int i = 0; i < 324; i++) mem[i] = {8{16'(i)}};
    mem[12] = RELU_PAT;

    vecs[0] = '{9'd0,   10'd324, 1'b0, 0, 1'b0, 324, 1'b1, {8{16'h0000}}};
    vecs[1] = '{9'd320, 10'd8,   1'b0, 0, 1'b0, 8,   1'b1, {8{16'h0140}}};
    vecs[2] = '{9'd5,   10'd6,   1'b0, 1, 1'b0, 6,   1'b1, {8{16'h0005}}};
    vecs[3] = '{9'd0,   10'd0,   1'b0, 0, 1'b0, 0,   1'b0, 128'h0};
    vecs[4] = '{9'd0,   10'd500, 1'b0, 0, 1'b0, 324, 1'b1, {8{16'h0000}}};
    vecs[5] = '{9'd12,  10'd1,   1'b1, 0, 1'b0, 1,   1'b1, RELU_EXP};
    vecs[6] = '{9'd12,  10'd1,   1'b0, 0, 1'b0, 1,   1'b1, RELU_PAT};
    vecs[7] = '{9'd100, 10'd40,  1'b0, 2, 1'b1, 40,  1'b1, {8{16'h0064}}};
    vecs[8] = '{9'd318, 10'd9,   1'b1, 1, 1'b0, 9,   1'b1, {8{16'h013E}}};

    rst_n = 1'b0; start = 1'b0; start_addr = '0; num_words = '0; relu_en = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy",   128'(busy), 128'(0));
    check("reset done",   128'(done), 128'(0));
    check("reset bram_en", 128'(bram_en), 128'(0));
    check("reset bram_addr", 128'(bram_addr), 128'(0));
    check("reset tvalid", 128'(m_axis_tvalid), 128'(0));
    check("reset tlast",  128'(m_axis_tlast), 128'(0));
    check("reset tdata",  m_axis_tdata, 128'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_vec(i, vecs[i]);
      if (i == 2) begin
        // start raised in the done cycle must be ignored
        start = 1'b1; start_addr = 9'd0; num_words = 10'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("start_in_done busy", 128'(busy), 128'(0));
        check("start_in_done bram_en", 128'(bram_en), 128'(0));
        repeat (3) @(negedge clk);
        check("start_in_done tvalid", 128'(m_axis_tvalid), 128'(0));
      end
    end

    // Reset in the middle of a 50-word drain
    @(negedge clk);
    m_axis_tready = 1'b1;
    hs_total = 0;
    start = 1'b1; start_addr = 9'd0; num_words = 10'd50; relu_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && hs_total < 10; c++) @(posedge clk);
    check("midrst beats_before_reset", 128'(hs_total >= 10), 128'(1));
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst busy",    128'(busy), 128'(0));
    check("midrst done",    128'(done), 128'(0));
    check("midrst bram_en", 128'(bram_en), 128'(0));
    check("midrst bram_addr", 128'(bram_addr), 128'(0));
    check("midrst tvalid",  128'(m_axis_tvalid), 128'(0));
    check("midrst tlast",   128'(m_axis_tlast), 128'(0));
    check("midrst tdata",   m_axis_tdata, 128'h0);
    done_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || m_axis_tvalid || bram_en) done_seen++;
    end
    check("midrst quiet_after", 128'(done_seen), 128'(0));
    run_vec(9, '{9'd7, 10'd12, 1'b0, 0, 1'b0, 12, 1'b1, {8{16'h0007}}});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
